// File: rtl/sim_mmio_responder.sv
// sim_mmio_responder: MMIO target used during simulation and bring-up.
// It decodes four word registers (TOHOST, CONSOLE, CYCLE, STATUS), buffers
// console bytes in a small FIFO, runs a watchdog, and reports the end of the
// run through o_done / o_pass / o_code.
module sim_mmio_responder #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_wstrb,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_done,
  output logic              o_pass,
  output logic [30:0]       o_code,
  output logic [31:0]       o_cycles
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [1:0] R_TOHOST  = 2'd0;
  localparam logic [1:0] R_CONSOLE = 2'd1;
  localparam logic [1:0] R_CYCLE   = 2'd2;
  localparam logic [1:0] R_STATUS  = 2'd3;

  state_e                   state_q, state_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [31:0]              rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic [31:0]              cycles_q, cycles_d;
  logic [31:0]              wdog_q, wdog_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [30:0]              code_q, code_d;

  logic [1:0] reg_sel;
  logic       fifo_full, fifo_empty, pop, push, acc, con_store, halt_store, halted;
  logic       req_ready;
  logic [7:0] level8;
  logic       unused_bits;

  assign reg_sel     = i_req_addr[3:2];
  assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign pop         = !fifo_empty && i_tx_ready;
  assign con_store   = i_req_we && (reg_sel == R_CONSOLE);
  // A full FIFO can still take a console byte when the head leaves this cycle.
  assign req_ready   = (state_q == S_RUN) && (!rsp_valid_q || i_rsp_ready) &&
                       !(con_store && fifo_full && !pop);
  assign acc         = i_req_valid && req_ready;
  assign push        = acc && con_store && i_req_wstrb[0];
  assign halt_store  = acc && i_req_we && (reg_sel == R_TOHOST) && (i_req_wdata != '0);
  assign halted      = (state_q != S_RUN);
  assign level8      = 8'(level_q);
  assign unused_bits = ^{i_req_addr, i_req_wstrb};

  // Response register: load on accept, clear once the core takes it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      unique case (reg_sel)
        R_TOHOST, R_CONSOLE: rsp_err_d = !i_req_we;
        R_CYCLE: begin
          rsp_err_d = i_req_we;
          if (!i_req_we) rsp_rdata_d = cycles_q;
        end
        default: begin
          rsp_err_d = i_req_we;
          if (!i_req_we) rsp_rdata_d = {21'd0, halted, fifo_full, fifo_empty, level8};
        end
      endcase
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Console FIFO: pointers wrap naturally because the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_req_wdata[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Run control: a halting TOHOST store beats a same-cycle watchdog expiry.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    pass_d   = pass_q;
    code_d   = code_q;
    wdog_d   = wdog_q;
    cycles_d = cycles_q + 32'd1;
    case (state_q)
      S_RUN: begin
        wdog_d = wdog_q + 32'd1;
        if (halt_store) begin
          state_d = S_DRAIN;
          pass_d  = (i_req_wdata == 32'd1);
          code_d  = i_req_wdata[31:1];
        end else if (wdog_q == 32'(TIMEOUT - 1)) begin
          state_d = S_DRAIN;
          pass_d  = 1'b0;
          code_d  = '1;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !rsp_valid_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // All state registers; reset drops FIFO contents and any pending response.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_RUN;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cycles_q    <= '0;
      wdog_q      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cycles_q    <= cycles_d;
      wdog_q      <= wdog_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_tx_valid  = !fifo_empty;
  assign o_tx_data   = mem_q[rd_ptr_q];
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_code      = code_q;
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_sim_mmio_responder.sv
// Directed bench for sim_mmio_responder: main instance with defaults plus a
// short-timeout instance that is left idle to exercise the watchdog.
module tb_sim_mmio_responder;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid, i_req_we, i_rsp_ready, i_tx_ready;
  logic [3:0]  i_req_addr, i_req_wstrb;
  logic [31:0] i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_tx_valid, o_done, o_pass;
  logic [31:0] o_rsp_rdata, o_cycles;
  logic [7:0]  o_tx_data;
  logic [30:0] o_code;

  logic        t_req_ready, t_rsp_valid, t_rsp_err, t_tx_valid, t_done, t_pass;
  logic [31:0] t_rsp_rdata, t_cycles;
  logic [7:0]  t_tx_data;
  logic [30:0] t_code;

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc_snap;

  always #5 i_clk = ~i_clk;

  sim_mmio_responder #(.ADDR_W(4), .FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_tx_data(o_tx_data), .o_done(o_done), .o_pass(o_pass), .o_code(o_code),
    .o_cycles(o_cycles)
  );

  sim_mmio_responder #(.ADDR_W(4), .FIFO_DEPTH(8), .TIMEOUT(50)) dut_to (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(1'b0), .o_req_ready(t_req_ready), .i_req_we(1'b0),
    .i_req_addr(4'd0), .i_req_wdata(32'd0), .i_req_wstrb(4'd0),
    .o_rsp_valid(t_rsp_valid), .i_rsp_ready(1'b1), .o_rsp_rdata(t_rsp_rdata),
    .o_rsp_err(t_rsp_err), .o_tx_valid(t_tx_valid), .i_tx_ready(1'b1),
    .o_tx_data(t_tx_data), .o_done(t_done), .o_pass(t_pass), .o_code(t_code),
    .o_cycles(t_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_wdata = d;
    i_req_wstrb = s;
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = 4'd0;
    i_req_wdata = 32'd0;
    i_req_wstrb = 4'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle();
    i_rst = 1'b0; i_rsp_ready = 1'b1; i_tx_ready = 1'b0;

    // reset
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_done", o_done, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_ready", o_req_ready, 1);
    i_rst = 1'b1;
    tick();
    chk("rst_cycles_1", o_cycles, 1);
    chk("rst_to_cycles_1", t_cycles, 1);

    // watchdog on the short-timeout instance
    for (int k = 0; k < 200 && !t_done; k++) tick();
    chk("to_done", t_done, 1);
    chk("to_cycle", t_cycles, 51);
    chk("to_pass", t_pass, 0);
    chk("to_code", t_code, 31'h7FFF_FFFF);
    chk("to_ready", t_req_ready, 0);

    // console bytes
    i_tx_ready = 1'b1;
    drive(1'b1, 4'h4, 32'h48, 4'h1);
    #1 chk("con_ready", o_req_ready, 1);
    tick();
    chk("con_h_rsp", o_rsp_valid, 1);
    chk("con_h_err", o_rsp_err, 0);
    chk("con_h_rdata", o_rsp_rdata, 0);
    chk("con_h_data", o_tx_data, 8'h48);
    drive(1'b1, 4'h4, 32'h69, 4'h1);
    tick();
    chk("con_i_rsp", o_rsp_valid, 1);
    chk("con_i_err", o_rsp_err, 0);
    chk("con_i_data", o_tx_data, 8'h69);
    idle();
    tick();
    chk("con_rsp_clear", o_rsp_valid, 0);
    chk("con_empty", o_tx_valid, 0);

    // backpressure: fill, stall 9th, one pop lets it in
    i_tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'h4, 32'h61 + k, 4'h1);
      tick();
    end
    drive(1'b1, 4'h4, 32'h69, 4'h1);
    #1 chk("bp_stall", o_req_ready, 0);
    tick();
    chk("bp_stall_hold", o_req_ready, 0);
    chk("bp_head", o_tx_data, 8'h61);
    i_tx_ready = 1'b1;
    #1 chk("bp_ready", o_req_ready, 1);
    tick();
    i_tx_ready = 1'b0;
    drive(1'b0, 4'hC, 32'd0, 4'h0);
    tick();
    chk("st_rdata", o_rsp_rdata, 32'h0000_0208);
    chk("st_err", o_rsp_err, 0);
    chk("st_head", o_tx_data, 8'h62);

    // access errors and register reads
    drive(1'b0, 4'h0, 32'd0, 4'h0);
    tick();
    chk("le_valid", o_rsp_valid, 1);
    chk("le_err", o_rsp_err, 1);
    chk("le_rdata", o_rsp_rdata, 0);
    drive(1'b1, 4'h8, 32'd5, 4'hF);
    tick();
    chk("se_err", o_rsp_err, 1);
    drive(1'b0, 4'h8, 32'd0, 4'h0);
    cyc_snap = o_cycles;
    tick();
    chk("cyc_rdata", o_rsp_rdata, cyc_snap);
    chk("cyc_err", o_rsp_err, 0);
    drive(1'b1, 4'h0, 32'd0, 4'hF);
    tick();
    chk("zero_err", o_rsp_err, 0);
    chk("zero_valid", o_rsp_valid, 1);
    idle();
    #1 chk("zero_ready", o_req_ready, 1);

    // cycle counter wrap
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1 release dut.cycles_q;
    #1 chk("wrap_pre", o_cycles, 32'hFFFF_FFFF);
    tick();
    chk("wrap", o_cycles, 0);

    // drain to 3 queued bytes, then pass
    i_tx_ready = 1'b1;
    repeat (5) tick();
    i_tx_ready = 1'b0;
    chk("drain_head", o_tx_data, 8'h67);
    drive(1'b1, 4'h0, 32'd1, 4'hF);
    tick();
    idle();
    #1 chk("p_drain_ready", o_req_ready, 0);
    chk("p_rsp", o_rsp_valid, 1);
    i_tx_ready = 1'b1;
    tick();
    chk("p_done_a", o_done, 0);
    tick();
    chk("p_done_b", o_done, 0);
    tick();
    chk("p_empty", o_tx_valid, 0);
    chk("p_done_c", o_done, 0);
    tick();
    chk("p_done", o_done, 1);
    chk("p_pass", o_pass, 1);
    chk("p_code", o_code, 0);

    // reset again, then a failing TOHOST value
    i_rst = 1'b0;
    #1 chk("rst2_done", o_done, 0);
    chk("rst2_cycles", o_cycles, 0);
    tick();
    i_rst = 1'b1;
    tick();
    drive(1'b1, 4'h0, 32'h0000_000B, 4'hF);
    tick();
    idle();
    for (int k = 0; k < 20 && !o_done; k++) tick();
    chk("f_done", o_done, 1);
    chk("f_pass", o_pass, 0);
    chk("f_code", o_code, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_mmio_responder.md
Name: sim_mmio_responder

Overview:
- Memory-mapped responder on the core's data bus for simulation and bring-up.
- Accepts load/store requests issued by the RISC-V core and returns responses.
- Buffers console bytes written by software in a FIFO and drains them on a byte stream.
- Captures the pass/fail code written to TOHOST, enforces a cycle watchdog, and raises o_done so the testbench ends the run.

Parameters:
- ADDR_W, 4, request byte-address width; only bits [3:2] are decoded.
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..64.
- TIMEOUT, 100000, cycles in RUN before a forced timeout halt.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  responder accepts request.
- i_req_we  in  1  1=store, 0=load.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  32  store data.
- i_req_wstrb  in  4  store byte enables.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  core takes response.
- o_rsp_rdata  out  32  load data; 0 for stores.
- o_rsp_err  out  1  access error.
- o_tx_valid  out  1  console byte valid.
- i_tx_ready  in  1  console sink ready.
- o_tx_data  out  8  console byte.
- o_done  out  1  run finished; sticky.
- o_pass  out  1  TOHOST value was 1; valid when o_done=1.
- o_code  out  31  fail code (TOHOST>>1), or all-ones on timeout.
- o_cycles  out  32  free-running cycle count.

Behaviour:
- Reset (i_rst=0, async) clears every output, FIFO pointers, counters, and the response register; state=RUN.
- Register map by addr[3:2]:
  - 0 TOHOST: W only.
  - 1 CONSOLE: W; byte = wdata[7:0]; pushes only if wstrb[0]=1.
  - 2 CYCLE: R returns o_cycles.
  - 3 STATUS: R returns {halted, full, empty, level[7:0]} in bits [10:0], other bits 0.
- Read of a W-only register, or write of an R-only register: response with o_rsp_err=1, rdata=0, no side effect.
- Handshake:
  - Request is accepted when i_req_valid && o_req_ready.
  - Response is registered; o_rsp_valid asserts the cycle after acceptance.
  - o_rsp_valid holds until i_rsp_ready.
  - o_req_ready = state==RUN && (!o_rsp_valid || i_rsp_ready) && !(CONSOLE store && FIFO full && !pop this cycle).
  - Back-to-back accepts are allowed, one per cycle.
- FIFO:
  - Head byte is presented on o_tx_data with o_tx_valid = !empty.
  - Pop occurs on o_tx_valid && i_tx_ready.
  - Push and pop in the same cycle when full is legal; level stays FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- o_cycles increments every cycle from 0 after reset and wraps at 2^32.
- State machine:
  - RUN -> DRAIN on an accepted TOHOST store with wdata!=0. o_pass=(wdata==1); o_code=wdata[31:1] are latched at acceptance.
  - RUN -> DRAIN when the watchdog reaches TIMEOUT-1 with no halt. o_pass=0, o_code=all-ones.
  - If a TOHOST store and watchdog expiry occur in the same cycle, the store wins.
  - A TOHOST store with wdata==0 is acknowledged as a no-op.
  - DRAIN: o_req_ready=0. An outstanding response still completes. The FIFO keeps draining.
  - DRAIN -> DONE when FIFO empty and !o_rsp_valid. DONE asserts o_done=1, held until reset.
- Watchdog counts only in RUN and freezes in DRAIN/DONE.
- Asserting reset mid-operation discards FIFO contents and any pending response immediately.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles, release -> all outputs 0, o_req_ready=1, o_cycles=1 one cycle after release.
- Console: store 'H','i' to addr 0x4 with i_tx_ready=1 -> o_tx_data 0x48 then 0x69; each response has err=0 and arrives one cycle after accept.
- Backpressure: i_tx_ready=0, store 9 bytes with FIFO_DEPTH=8 -> 9th request stalls with o_req_ready=0; raising i_tx_ready for one pop accepts it; STATUS read then returns level=8.
- Pass: store 1 to TOHOST while 3 bytes are queued -> o_done rises only after the 3rd byte pops, with o_pass=1, o_code=0.
- Fail and timeout:
  - Store 0x0000000B to TOHOST -> o_done=1, o_pass=0, o_code=5.
  - Separately, with TIMEOUT=50 and no store -> o_done=1 at cycle 51, o_code=all-ones.
- Errors and wrap: load from TOHOST -> o_rsp_err=1, rdata=0. Force o_cycles to 0xFFFFFFFF -> next value 0.
